assert_event_log: RTL and testbench
===================================

Name: assert_event_log

Overview:
- Downstream consumer of the concurrent-assertion checkers in the regression environment.
- Takes per-assertion pass/fail pulses, keeps saturating pass/fail counters, and timestamps each failure.
- Queues failures in a FIFO and drains them over a valid/ready interface to a host/monitor.
- Lets a bench or on-chip debug port audit how assertions such as intersect properties fired, cycle by cycle.

Parameters:
- NUM_ASSERT, 4, number of monitored assertions (2..16).
- DEPTH, 8, failure FIFO entries (power of two, >=2).
- TS_W, 32, cycle timestamp width.
- CNT_W, 16, width of each pass/fail counter.

Ports:
- clk  input  1  single clock, all state on posedge.
- rst  input  1  asynchronous, active-high reset.
- pass_i  input  NUM_ASSERT  per-assertion pass pulse, sampled each posedge.
- fail_i  input  NUM_ASSERT  per-assertion fail pulse, sampled each posedge.
- clr_i  input  1  synchronous clear of counters and sticky flags.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head.
- out_id  output  $clog2(NUM_ASSERT)  assertion index of head entry.
- out_ts  output  TS_W  timestamp of head entry.
- cnt_sel  input  $clog2(NUM_ASSERT)  counter read select.
- pass_cnt  output  CNT_W  pass count of selected assertion (combinational read).
- fail_cnt  output  CNT_W  fail count of selected assertion (combinational read).
- overflow  output  1  sticky: a failure event was dropped.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst high, async):
  - ts counter = 0; all counters = 0; pending bits = 0; FIFO empty.
  - out_valid = 0, out_id = 0, out_ts = 0, overflow = 0, level = 0.
- Timestamp counter: increments every cycle after reset; wraps 2^TS_W-1 -> 0. The timestamp of an event = counter value at the sampling edge, before increment.
- Counters:
  - At each edge, pass_cnt[i] += pass_i[i] and fail_cnt[i] += fail_i[i].
  - Counters saturate at all-ones with no wrap.
  - pass_i and fail_i both high for the same i in the same cycle: both counters increment.
- clr_i: at the edge, zeroes all counters and overflow. It does not touch the FIFO, pending bits or timestamp. If clr_i and a pulse occur in the same cycle, clr wins and the counter ends at 0.
- Pending stage:
  - fail_i[i] high at an edge sets pend[i] and captures pend_ts[i] = timestamp.
  - If pend[i] is already set and not being drained this same edge, the new failure is dropped and overflow is set (its counter still increments).
  - If pend[i] is drained at the same edge as a new fail on i, pend[i] stays set with the new timestamp, and no overflow.
- Arbiter:
  - Each edge, if FIFO is not full (or a pop happens the same edge), the lowest-index set pend bit is pushed as {i, pend_ts[i]} and cleared.
  - One push per cycle maximum.
- FIFO:
  - Head shown on out_id/out_ts with out_valid; pop when out_valid && out_ready.
  - Simultaneous push and pop when full is legal; level stays DEPTH.
  - Pointers wrap modulo DEPTH.
  - out_id/out_ts hold their value while out_valid = 0.
- Latency: fail_i high at edge E -> pend at E -> pushed at E+1 if arbitration is won -> out_valid = 1 after E+1 (2 edges minimum).
- Full: pending bits hold until space is available; overflow is set only by the pending-collision rule above.
- Reset mid-operation discards everything immediately.

Test Plan:
- Reset release, then fail_i = 4'b0001 at ts 5, out_ready = 1 -> out_valid pulses with out_id = 0, out_ts = 5, exactly 2 edges after the sample; fail_cnt(sel 0) = 1.
- fail_i = 4'b1011 in a single cycle at ts 10, out_ready = 1 -> three entries in order id 0, 1, 3, all ts = 10, on consecutive cycles; overflow = 0.
- out_ready = 0, fail_i[2] pulsed 12 times at consecutive cycles -> level saturates at 8; overflow = 1 once collisions occur; fail_cnt(sel 2) = 12; then out_ready = 1 drains 8 entries with ascending ts, then the remaining pending entry.
- pass_i[1] held high 70000 cycles with CNT_W = 16 -> pass_cnt(sel 1) = 65535; then clr_i for 1 cycle -> pass_cnt = 0, overflow = 0, FIFO contents intact.
- FIFO full, with a pop and a push in the same cycle -> level stays 8, head advances, and the new entry appears last.
- Assert rst mid-drain with 5 entries queued -> out_valid = 0, level = 0, counters = 0 immediately; the first fail after release reports ts = 0-based count.

Source files
------------

// File: rtl/assert_event_log.sv
// assert_event_log: saturating per-assertion pass/fail counters plus a timestamped failure FIFO.
// Each assertion has a one-deep pending slot. A fixed-priority arbiter moves the pending slots into the FIFO.
module assert_event_log #(
    parameter int NUM_ASSERT = 4,
    parameter int DEPTH      = 8,
    parameter int TS_W       = 32,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_ASSERT-1:0]         pass_i,
    input  logic [NUM_ASSERT-1:0]         fail_i,
    input  logic                          clr_i,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(NUM_ASSERT)-1:0] out_id,
    output logic [TS_W-1:0]               out_ts,
    input  logic [$clog2(NUM_ASSERT)-1:0] cnt_sel,
    output logic [CNT_W-1:0]              pass_cnt,
    output logic [CNT_W-1:0]              fail_cnt,
    output logic                          overflow,
    output logic [$clog2(DEPTH):0]        level
);
    localparam int IW = $clog2(NUM_ASSERT);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = IW + TS_W;

    logic [TS_W-1:0]       ts;
    logic [CNT_W-1:0]      pass_c [NUM_ASSERT];
    logic [CNT_W-1:0]      fail_c [NUM_ASSERT];
    logic [NUM_ASSERT-1:0] pend;
    logic [TS_W-1:0]       pend_ts [NUM_ASSERT];
    logic [EW-1:0]         mem [DEPTH];
    logic [EW-1:0]         hold;
    logic [AW-1:0]         wp, rp;
    logic [AW:0]           cnt;
    logic [IW-1:0]         sel_id;
    logic                  found, push, pop;
    logic [NUM_ASSERT-1:0] drain;

    always_comb begin
        sel_id = '0;
        found  = 1'b0;
        for (int i = NUM_ASSERT - 1; i >= 0; i--)
            if (pend[i]) begin
                sel_id = IW'(i);
                found  = 1'b1;
            end
    end

    assign out_valid = cnt != '0;
    assign pop       = out_valid && out_ready;
    assign push      = found && (cnt != (AW+1)'(DEPTH) || pop);
    assign drain     = push ? NUM_ASSERT'(1) << sel_id : '0;
    assign {out_id, out_ts} = out_valid ? mem[rp] : hold;
    assign pass_cnt  = pass_c[cnt_sel];
    assign fail_cnt  = fail_c[cnt_sel];
    assign level     = cnt;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ts       <= '0;
            pend     <= '0;
            overflow <= 1'b0;
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            hold     <= '0;
            for (int i = 0; i < NUM_ASSERT; i++) begin
                pass_c[i]  <= '0;
                fail_c[i]  <= '0;
                pend_ts[i] <= '0;
            end
        end else begin
            ts <= ts + 1'b1;
            for (int i = 0; i < NUM_ASSERT; i++) begin
                pass_c[i] <= clr_i ? '0 : pass_c[i] + CNT_W'(pass_i[i] && !(&pass_c[i]));
                fail_c[i] <= clr_i ? '0 : fail_c[i] + CNT_W'(fail_i[i] && !(&fail_c[i]));
                if (fail_i[i] && (!pend[i] || drain[i]))
                    pend_ts[i] <= ts;
            end
            // A fail on an occupied, non-draining slot is dropped but leaves the slot set.
            pend     <= fail_i | (pend & ~drain);
            overflow <= clr_i ? 1'b0 : overflow | (|(fail_i & pend & ~drain));
            if (push)
                wp <= wp + 1'b1;
            if (pop) begin
                rp   <= rp + 1'b1;
                hold <= mem[rp];
            end
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end

    always_ff @(posedge clk)
        if (push)
            mem[wp] <= {sel_id, pend_ts[sel_id]};
endmodule

// File: tb/tb_assert_event_log.sv
// tb_assert_event_log: directed vectors plus hand-written FIFO, overflow, saturation and reset sequences.
module tb_assert_event_log;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  pass_i = '0, fail_i = '0;
    logic        clr_i = 1'b0, out_ready = 1'b0;
    logic        out_valid, overflow;
    logic [1:0]  out_id, cnt_sel = '0;
    logic [31:0] out_ts;
    logic [15:0] pass_cnt, fail_cnt;
    logic [3:0]  level;
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        logic [3:0]  p;
        logic [3:0]  f;
        logic        c;
        logic [1:0]  s;
        logic [15:0] ep;
        logic [15:0] ef;
    } vec_t;
    vec_t tbl [8];

    assert_event_log dut (
        .clk(clk), .rst(rst), .pass_i(pass_i), .fail_i(fail_i), .clr_i(clr_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_ts(out_ts),
        .cnt_sel(cnt_sel), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .overflow(overflow), .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tbl[0] = '{4'b0001, 4'b0000, 1'b0, 2'd0, 16'd1, 16'd0};
        tbl[1] = '{4'b0011, 4'b0010, 1'b0, 2'd1, 16'd1, 16'd1};
        tbl[2] = '{4'b0001, 4'b0001, 1'b0, 2'd0, 16'd3, 16'd1};
        tbl[3] = '{4'b1111, 4'b1111, 1'b0, 2'd3, 16'd1, 16'd1};
        tbl[4] = '{4'b0000, 4'b0000, 1'b1, 2'd0, 16'd0, 16'd0};
        tbl[5] = '{4'b0010, 4'b0010, 1'b1, 2'd1, 16'd0, 16'd0};
        tbl[6] = '{4'b0100, 4'b0000, 1'b0, 2'd2, 16'd1, 16'd0};
        tbl[7] = '{4'b0000, 4'b0000, 1'b0, 2'd3, 16'd0, 16'd0};

        // reset state
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_level", 32'(level), 0);
        check("rst_id", 32'(out_id), 0);
        check("rst_ts", out_ts, 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_pcnt", 32'(pass_cnt), 0);
        check("rst_fcnt", 32'(fail_cnt), 0);

        // counter vectors
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pass_i = tbl[i].p; fail_i = tbl[i].f; clr_i = tbl[i].c; cnt_sel = tbl[i].s;
            @(negedge clk);
            check($sformatf("vec%0d_pass", i), 32'(pass_cnt), 32'(tbl[i].ep));
            check($sformatf("vec%0d_fail", i), 32'(fail_cnt), 32'(tbl[i].ef));
        end
        pass_i = '0; fail_i = '0; clr_i = 1'b0;
        check("vec_ovf", 32'(overflow), 0);

        // single fail at ts 5, two-edge latency
        do_reset();
        out_ready = 1'b1; cnt_sel = 2'd0;
        repeat (5) @(negedge clk);
        fail_i = 4'b0001;
        @(negedge clk);
        fail_i = '0;
        check("lat_not_yet", 32'(out_valid), 0);
        @(negedge clk);
        check("lat_valid", 32'(out_valid), 1);
        check("lat_id", 32'(out_id), 0);
        check("lat_ts", out_ts, 5);
        check("lat_fcnt", 32'(fail_cnt), 1);
        @(negedge clk);
        check("lat_popped", 32'(out_valid), 0);
        check("lat_hold_ts", out_ts, 5);

        // multi-fail in one cycle at ts 10: ids 0,1,3 in order
        do_reset();
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        fail_i = 4'b1011;
        @(negedge clk);
        fail_i = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("multi%0d_valid", k), 32'(out_valid), 1);
            check($sformatf("multi%0d_id", k), 32'(out_id), (k == 2) ? 3 : k);
            check($sformatf("multi%0d_ts", k), out_ts, 10);
        end
        @(negedge clk);
        check("multi_empty", 32'(out_valid), 0);
        check("multi_ovf", 32'(overflow), 0);

        // fill with out_ready low, collisions, then drain incl. simultaneous push/pop at full
        do_reset();
        out_ready = 1'b0; cnt_sel = 2'd2;
        repeat (2) @(negedge clk);
        fail_i = 4'b0100;
        repeat (12) @(negedge clk);
        fail_i = '0;
        check("full_level", 32'(level), 8);
        check("full_ovf", 32'(overflow), 1);
        check("full_fcnt", 32'(fail_cnt), 12);
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            check($sformatf("drain%0d_valid", k), 32'(out_valid), 1);
            check($sformatf("drain%0d_id", k), 32'(out_id), 2);
            check($sformatf("drain%0d_ts", k), out_ts, 32'(2 + k));
            @(negedge clk);
            if (k == 0) check("pushpop_level", 32'(level), 8);
        end
        check("drain_empty", 32'(out_valid), 0);
        check("drain_hold_ts", out_ts, 10);

        // counter saturation and clear with FIFO full and overflow set
        do_reset();
        out_ready = 1'b0;
        fail_i = 4'b0001;
        repeat (11) @(negedge clk);
        fail_i = '0;
        check("sat_ovf_set", 32'(overflow), 1);
        pass_i = 4'b0010;
        repeat (70000) @(negedge clk);
        cnt_sel = 2'd1;
        #1 check("sat_pcnt", 32'(pass_cnt), 65535);
        cnt_sel = 2'd0;
        #1 check("sat_fcnt", 32'(fail_cnt), 11);
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        check("clr_fcnt", 32'(fail_cnt), 0);
        cnt_sel = 2'd1;
        #1 check("clr_pcnt", 32'(pass_cnt), 0);
        pass_i = '0;
        check("clr_ovf", 32'(overflow), 0);
        check("clr_level", 32'(level), 8);
        check("clr_head_valid", 32'(out_valid), 1);
        check("clr_head_ts", out_ts, 0);

        // async reset mid-drain
        do_reset();
        out_ready = 1'b0; cnt_sel = 2'd0;
        fail_i = 4'b0001;
        repeat (5) @(negedge clk);
        fail_i = '0;
        @(negedge clk);
        check("pre_rst_level", 32'(level), 5);
        out_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_level", 32'(level), 0);
        check("mid_rst_fcnt", 32'(fail_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        fail_i = 4'b0001;
        @(negedge clk);
        fail_i = '0;
        @(negedge clk);
        check("post_rst_valid", 32'(out_valid), 1);
        check("post_rst_ts", out_ts, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
